header_buffer: RTL

//  80-byte block-header store between the host command controller and the hash core.
//  - The controller writes received bytes (load/address), one byte per cycle.
//  - On start_hash the block streams the header to the core as 20 big-endian 32-bit words

---
 rtl/header_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/header_buffer.sv
// Block-header store: byte-wide writes from the command controller, 32-bit big-endian
// word stream to the hash core, and an in-place little-endian nonce increment.
module header_buffer #(
    parameter int NUM_BYTES  = 80,
    parameter int NONCE_ADDR = 76
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [6:0]  address,
    input  logic [7:0]  rx_data,
    input  logic        start_hash,
    input  logic        nonce_inc,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_last,
    output logic        stream_busy,
    output logic [31:0] nonce_out,
    output logic        write_err
);

    localparam int ADDR_W    = 7;
    localparam int NUM_WORDS = NUM_BYTES / 4;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] LIMIT    = ADDR_W'(NUM_BYTES);
    localparam logic [ADDR_W-1:0] NONCE_B0 = ADDR_W'(NONCE_ADDR);
    localparam logic [ADDR_W-1:0] NONCE_B1 = ADDR_W'(NONCE_ADDR + 1);
    localparam logic [ADDR_W-1:0] NONCE_B2 = ADDR_W'(NONCE_ADDR + 2);
    localparam logic [ADDR_W-1:0] NONCE_B3 = ADDR_W'(NONCE_ADDR + 3);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        mem [NUM_BYTES];
    logic [IDX_W-1:0]  idx;
    logic              inc_pending;

    logic              in_idle;
    logic              in_stream;
    logic              handshake;
    logic              stream_done;
    logic              write_ok;
    logic              load_nonce;
    logic              do_inc;
    logic [ADDR_W-1:0] base;
    logic [31:0]       nonce_next;

    assign in_idle     = (state == IDLE);
    assign in_stream   = (state == STREAM);
    assign handshake   = in_stream & word_ready;
    assign stream_done = handshake & (idx == LAST_IDX);

    assign write_ok   = load & in_idle & (address < LIMIT);
    assign load_nonce = write_ok & (address >= NONCE_B0) & (address <= NONCE_B3);

    // A same-cycle load to any nonce byte overrides the increment entirely;
    // a deferred increment lands on the edge that leaves STREAM.
    assign do_inc = (in_idle & nonce_inc & ~load_nonce)
                  | (stream_done & (inc_pending | nonce_inc));

    assign base       = ADDR_W'({idx, 2'b00});
    assign word_out   = {mem[base], mem[base + 7'd1], mem[base + 7'd2], mem[base + 7'd3]};
    assign word_valid = in_stream;
    assign word_last  = in_stream & (idx == LAST_IDX);
    assign stream_busy = in_stream;

    assign nonce_out  = {mem[NONCE_B3], mem[NONCE_B2], mem[NONCE_B1], mem[NONCE_B0]};
    assign nonce_next = nonce_out + 32'd1;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_hash)  state_next = STREAM;
            STREAM:  if (stream_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            inc_pending <= 1'b0;
            write_err   <= 1'b0;
        end else begin
            state     <= state_next;
            write_err <= load & (in_stream | (address >= LIMIT));
            if (in_idle & start_hash) begin
                idx <= '0;
            end else if (handshake) begin
                idx <= stream_done ? '0 : idx + 1'b1;
            end
            if (stream_done) begin
                inc_pending <= 1'b0;
            end else if (in_stream & nonce_inc) begin
                inc_pending <= 1'b1;
            end
        end
    end

    // Header memory; the load is placed after the increment so it wins on overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_inc) begin
                for (int k = 0; k < 4; k++) begin
                    mem[NONCE_B0 + ADDR_W'(k)] <= nonce_next[8*k +: 8];
                end
            end
            if (write_ok) begin
                mem[address] <= rx_data;
            end
        end
    end

endmodule
